sysx_mask_ctrl: RTL and testbench

- Sequencing controller for the SystemX 2-share masked evaluation gadget, computing F = ~C & (~A | B) on shared A, B and C.
- Collects fresh randomness from the shared PRNG stream and guarantees 8 never-reused mask bits per evaluation.
- Launches one evaluation per accepted input, waits a fixed gadget latency, then returns the output shares over a valid/ready handshake.
- Sits between the share-producing front end and the gadget; the gadget connects externally on the g_* ports.

---
 rtl/sysx_mask_ctrl_pkg.sv | 33 +++
 rtl/sysx_mask_ctrl_if.sv | 37 +++
 rtl/sysx_mask_ctrl_rand_buf.sv | 72 +++++++
 rtl/sysx_mask_ctrl.sv | 165 ++++++++++++++++
 tb/tb_sysx_mask_ctrl.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sysx_mask_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sysx_mask_pkg
// Shared types and constants for the SystemX masked-gadget sequencing
// controller (sysx_mask_ctrl) and its random collection buffer.
//   state_t      : controller FSM states
//   RAND_BITS    : mask bits handed to the gadget per evaluation
//   SHARE_W      : width of the packed share vector {C1,C0,B1,B0,A1,A0}
//   IDX_*        : bit positions of the individual shares in that vector
//   rand_words() : number of PRNG words needed to fill the mask buffer
// ---------------------------------------------------------------------------
package sysx_mask_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int RAND_BITS = 8;
  localparam int SHARE_W   = 6;

  localparam int IDX_A0 = 0;
  localparam int IDX_A1 = 1;
  localparam int IDX_B0 = 2;
  localparam int IDX_B1 = 3;
  localparam int IDX_C0 = 4;
  localparam int IDX_C1 = 5;

  function automatic int rand_words(input int rw);
    return RAND_BITS / rw;
  endfunction

endpackage

// File: rtl/sysx_mask_ctrl_if.sv
// ---------------------------------------------------------------------------
// sysx_mask_ctrl_if
// Handshake bundle around the masked-gadget controller.
//   in_valid/in_ready/in_shares   : share vector from the front end
//   rnd_valid/rnd_ready/rnd_data  : PRNG word stream (RW bits per word)
//   out_valid/out_ready/out_shares: output shares {F1,F0} to downstream
// Modports: master = environment side (front end, PRNG, sink),
//           slave  = controller side.
// ---------------------------------------------------------------------------
interface sysx_mask_ctrl_if #(
  parameter int RW = 1
);
  import sysx_mask_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [SHARE_W-1:0] in_shares;

  logic               rnd_valid;
  logic               rnd_ready;
  logic [RW-1:0]      rnd_data;

  logic               out_valid;
  logic               out_ready;
  logic [1:0]         out_shares;

  modport master (
    output in_valid, in_shares, rnd_valid, rnd_data, out_ready,
    input  in_ready, rnd_ready, out_valid, out_shares
  );

  modport slave (
    input  in_valid, in_shares, rnd_valid, rnd_data, out_ready,
    output in_ready, rnd_ready, out_valid, out_shares
  );

endinterface

// File: rtl/sysx_mask_ctrl_rand_buf.sv
// ---------------------------------------------------------------------------
// sysx_rand_buf
// Collects RAND_BITS fresh mask bits from an RW-bit PRNG stream.
// Word j lands in bits [j*RW +: RW]. The buffer is full after RAND_BITS/RW
// accepted words and is emptied and zeroed by clr (asserted on launch).
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   wr_valid/wr_ready   : PRNG word handshake (wr_ready = !full)
//   wr_data             : PRNG word
//   clr                 : empty the buffer this edge (has priority)
//   full                : all mask bits present
//   data                : collected mask bits
// ---------------------------------------------------------------------------
module sysx_rand_buf
  import sysx_mask_pkg::*;
#(
  parameter int RW = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_valid,
  input  logic [RW-1:0]        wr_data,
  input  logic                 clr,
  output logic                 wr_ready,
  output logic                 full,
  output logic [RAND_BITS-1:0] data
);

  localparam int         WORDS   = rand_words(RW);
  localparam logic [3:0] WORDS_C = 4'(WORDS);

  logic [RAND_BITS-1:0] data_reg, data_next;
  logic [3:0]           count_reg, count_next;
  logic [WORDS-1:0]     word_sel;
  logic                 wr_en;

  assign full     = (count_reg == WORDS_C);
  assign wr_ready = !full;
  assign wr_en    = wr_valid && !full;
  assign data     = data_reg;

  // One-hot select of the slot the next accepted word goes into
  for (genvar gi = 0; gi < WORDS; gi++) begin : g_sel
    assign word_sel[gi] = wr_en && (count_reg == 4'(gi));
  end

  always_comb begin
    data_next  = data_reg;
    count_next = count_reg;
    if (clr) begin
      // Consumed bits are wiped so they can never reach the gadget twice
      data_next  = '0;
      count_next = '0;
    end else if (wr_en) begin
      for (int i = 0; i < WORDS; i++) begin
        if (word_sel[i]) data_next[i*RW +: RW] = wr_data;
      end
      count_next = count_reg + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg  <= '0;
      count_reg <= '0;
    end else begin
      data_reg  <= data_next;
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/sysx_mask_ctrl.sv
// ---------------------------------------------------------------------------
// sysx_mask_ctrl
// Sequencing controller for the SystemX 2-share masked gadget computing
// F = ~C & (~A | B). Accepts one share vector when a full buffer of fresh
// mask bits is available, drives the gadget for LAT cycles, then returns
// the gadget's output shares over a valid/ready handshake. Share pairs are
// only ever routed, never combined.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   bus         : sysx_mask_ctrl_if.slave (input, PRNG and output handshakes)
//   g_in, g_r   : registered shares / mask bits to the gadget
//   g_out       : gadget output shares {F1,F0}
//   busy        : FSM not idle
//   stall_cnt   : (only with SYSX_STALL_CNT_EN) saturating count of cycles
//                 an input waited solely for randomness
// Parameters: RW = PRNG word width (1,2,4,8), LAT = gadget latency (>= 1).
// Optional feature macro: SYSX_STALL_CNT_EN.
// ---------------------------------------------------------------------------
module sysx_mask_ctrl
  import sysx_mask_pkg::*;
#(
  parameter int RW  = 1,
  parameter int LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sysx_mask_ctrl_if.slave      bus,
  output logic [SHARE_W-1:0]   g_in,
  output logic [RAND_BITS-1:0] g_r,
  input  logic [1:0]           g_out,
  output logic                 busy
`ifdef SYSX_STALL_CNT_EN
  ,
  output logic [15:0]          stall_cnt
`endif
);

  localparam int          CW     = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] LAT_M1 = CW'(LAT - 1);

  state_t               state_reg, state_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [SHARE_W-1:0]   g_in_reg, g_in_next;
  logic [RAND_BITS-1:0] g_r_reg, g_r_next;
  logic [1:0]           out_shares_reg, out_shares_next;
  logic                 out_valid_reg, out_valid_next;

  logic                 rnd_full;
  logic [RAND_BITS-1:0] rnd_bits;
  logic                 launch_ok;
  logic                 in_ready;
  logic                 launch;

  // A launch slot exists when idle, or when the current result is being
  // taken this very cycle. Independent of in_valid by construction.
  assign launch_ok = (state_reg == IDLE) || ((state_reg == OUT) && bus.out_ready);
  assign in_ready  = rnd_full && launch_ok;
  assign launch    = bus.in_valid && in_ready;

  sysx_rand_buf #(
    .RW(RW)
  ) u_rand_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (bus.rnd_valid),
    .wr_data  (bus.rnd_data),
    .clr      (launch),
    .wr_ready (bus.rnd_ready),
    .full     (rnd_full),
    .data     (rnd_bits)
  );

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    g_in_next       = g_in_reg;
    g_r_next        = g_r_reg;
    out_shares_next = out_shares_reg;
    out_valid_next  = out_valid_reg;

    case (state_reg)
      IDLE: begin
        if (launch) begin
          g_in_next  = bus.in_shares;
          g_r_next   = rnd_bits;
          cnt_next   = LAT_M1;
          state_next = EVAL;
        end
      end
      EVAL: begin
        if (cnt_reg == '0) begin
          out_shares_next = g_out;
          out_valid_next  = 1'b1;
          // Drop the gadget inputs as soon as the result is captured
          g_in_next       = '0;
          g_r_next        = '0;
          state_next      = OUT;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          if (launch) begin
            // Back-to-back: out_valid is left high across the relaunch
            g_in_next  = bus.in_shares;
            g_r_next   = rnd_bits;
            cnt_next   = LAT_M1;
            state_next = EVAL;
          end else begin
            out_valid_next = 1'b0;
            state_next     = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      g_in_reg       <= '0;
      g_r_reg        <= '0;
      out_shares_reg <= '0;
      out_valid_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      g_in_reg       <= g_in_next;
      g_r_reg        <= g_r_next;
      out_shares_reg <= out_shares_next;
      out_valid_reg  <= out_valid_next;
    end
  end

  assign g_in           = g_in_reg;
  assign g_r            = g_r_reg;
  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_reg;
  assign bus.out_shares = out_shares_reg;
  assign busy           = (state_reg != IDLE);

`ifdef SYSX_STALL_CNT_EN
  logic [15:0] stall_cnt_reg;
  logic        stall_cond;

  // Input waiting, launch slot open, only randomness missing
  assign stall_cond = bus.in_valid && !rnd_full && launch_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (stall_cond && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_sysx_mask_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sysx_mask_ctrl
// Directed bench for sysx_mask_ctrl. Two instances: RW=8 (main function,
// back-to-back, reset mid-evaluation) and RW=1 (bit-serial mask collection,
// stall counter when SYSX_STALL_CNT_EN is defined). Both use LAT=2 and a
// behavioural gadget that recovers F from the shares and re-masks it.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sysx_mask_ctrl;
  import sysx_mask_pkg::*;

  localparam int LAT = 2;

  logic clk;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  sysx_mask_ctrl_if #(.RW(8)) bus8 ();
  sysx_mask_ctrl_if #(.RW(1)) bus1 ();

  logic [5:0] g_in8, g_in1;
  logic [7:0] g_r8, g_r1;
  logic [1:0] g_out8, g_out1;
  logic       busy8, busy1;
`ifdef SYSX_STALL_CNT_EN
  logic [15:0] stall8, stall1;
`endif

  // Gadget model: F truth table indexed by {C,B,A}, output re-masked by r0
  function automatic logic [1:0] gadget(input logic [5:0] s, input logic [7:0] r);
    logic [7:0] tt;
    logic [2:0] idx;
    tt  = 8'b0000_1101;
    idx = {s[IDX_C1] ^ s[IDX_C0], s[IDX_B1] ^ s[IDX_B0], s[IDX_A1] ^ s[IDX_A0]};
    return {tt[idx] ^ r[0], r[0]};
  endfunction

  assign g_out8 = gadget(g_in8, g_r8);
  assign g_out1 = gadget(g_in1, g_r1);

  sysx_mask_ctrl #(.RW(8), .LAT(LAT)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8),
    .g_in  (g_in8),
    .g_r   (g_r8),
    .g_out (g_out8),
    .busy  (busy8)
`ifdef SYSX_STALL_CNT_EN
    ,
    .stall_cnt (stall8)
`endif
  );

  sysx_mask_ctrl #(.RW(1), .LAT(LAT)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1),
    .g_in  (g_in1),
    .g_r   (g_r1),
    .g_out (g_out1),
    .busy  (busy1)
`ifdef SYSX_STALL_CNT_EN
    ,
    .stall_cnt (stall1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full evaluation on the RW=8 instance with a random share split
  task automatic do_eval(input logic a, input logic b, input logic c, input logic [7:0] rw);
    logic [5:0] sh;
    logic [2:0] m;
    logic       ef;
    int         lat;
    m  = 3'($urandom);
    sh = {c ^ m[2], m[2], b ^ m[1], m[1], a ^ m[0], m[0]};
    ef = ~c & (~a | b);

    bus8.rnd_valid = 1'b1;
    bus8.rnd_data  = rw;
    tick();
    bus8.rnd_valid = 1'b0;
    check_val("rnd_ready_full", 32'(bus8.rnd_ready), 32'd0);

    bus8.in_valid  = 1'b1;
    bus8.in_shares = sh;
    #1;
    check_val("in_ready", 32'(bus8.in_ready), 32'd1);
    tick();
    bus8.in_valid = 1'b0;
    check_val("g_in_eval", 32'(g_in8), 32'(sh));
    check_val("g_r_eval", 32'(g_r8), 32'(rw));
    check_val("busy_eval", 32'(busy8), 32'd1);

    lat = 0;
    while (!bus8.out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check_val("latency", 32'(lat), 32'(LAT));
    check_val("f_value", 32'(bus8.out_shares[0] ^ bus8.out_shares[1]), 32'(ef));
    check_val("g_in_cleared", 32'(g_in8), 32'd0);
    check_val("g_r_cleared", 32'(g_r8), 32'd0);
    $display("eval a=%0d b=%0d c=%0d shares=%b r=%h out=%b latency=%0d", a, b, c, sh, rw,
             bus8.out_shares, lat);

    bus8.out_ready = 1'b1;
    tick();
    bus8.out_ready = 1'b0;
    check_val("out_valid_drop", 32'(bus8.out_valid), 32'd0);
    check_val("busy_idle", 32'(busy8), 32'd0);
  endtask

  initial begin
    logic [1:0] held;
    logic [5:0] sh2;
    logic [7:0] pat;
    int         lat;

    rst_n = 1'b0;
    bus8.in_valid = 1'b0; bus8.in_shares = '0; bus8.rnd_valid = 1'b0;
    bus8.rnd_data = '0;   bus8.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_shares = '0; bus1.rnd_valid = 1'b0;
    bus1.rnd_data = '0;   bus1.out_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    #1;

    // Reset state
    check_val("rst_out_valid", 32'(bus8.out_valid), 32'd0);
    check_val("rst_in_ready", 32'(bus8.in_ready), 32'd0);
    check_val("rst_rnd_ready", 32'(bus8.rnd_ready), 32'd1);
    check_val("rst_g_in", 32'(g_in8), 32'd0);
    check_val("rst_g_r", 32'(g_r8), 32'd0);
    check_val("rst_out_shares", 32'(bus8.out_shares), 32'd0);
    check_val("rst_busy", 32'(busy8), 32'd0);

    // A=B=C=0 with mask word A5
    do_eval(1'b0, 1'b0, 1'b0, 8'hA5);

    // Exhaustive A,B,C
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      do_eval(v[0], v[1], v[2], 8'($urandom));
    end

    // Starved input: no randomness, no launch
    bus8.in_valid  = 1'b1;
    bus8.in_shares = 6'b000001;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("starve_in_ready", 32'(bus8.in_ready), 32'd0);
      check_val("starve_busy", 32'(busy8), 32'd0);
    end
    bus8.in_valid = 1'b0;

    // Output held under backpressure, then back-to-back launch
    bus8.rnd_valid = 1'b1; bus8.rnd_data = 8'h3C;
    tick();
    bus8.rnd_valid = 1'b0;
    bus8.in_valid  = 1'b1;
    bus8.in_shares = 6'b000101;              // A=1, B=1, C=0 -> F=1
    tick();
    bus8.in_valid = 1'b0;
    lat = 0;
    while (!bus8.out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check_val("b2b_first_valid", 32'(bus8.out_valid), 32'd1);
    check_val("b2b_first_f", 32'(bus8.out_shares[0] ^ bus8.out_shares[1]), 32'd1);
    held = bus8.out_shares;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("hold_shares", 32'(bus8.out_shares), 32'(held));
      check_val("hold_valid", 32'(bus8.out_valid), 32'd1);
      check_val("hold_in_ready", 32'(bus8.in_ready), 32'd0);
    end
    bus8.rnd_valid = 1'b1; bus8.rnd_data = 8'h96;
    tick();
    bus8.rnd_valid = 1'b0;
    check_val("hold_full_no_ready", 32'(bus8.in_ready), 32'd0);
    sh2 = 6'b000001;                         // A=1, B=0, C=0 -> F=0
    bus8.in_valid  = 1'b1;
    bus8.in_shares = sh2;
    bus8.out_ready = 1'b1;
    #1;
    check_val("b2b_in_ready", 32'(bus8.in_ready), 32'd1);
    tick();
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b0;
    check_val("b2b_valid_kept", 32'(bus8.out_valid), 32'd1);
    check_val("b2b_busy", 32'(busy8), 32'd1);
    check_val("b2b_g_r", 32'(g_r8), 32'h96);
    check_val("b2b_g_in", 32'(g_in8), 32'(sh2));
    tick();
    check_val("b2b_valid_mid", 32'(bus8.out_valid), 32'd1);
    check_val("b2b_g_in_mid", 32'(g_in8), 32'(sh2));
    tick();
    check_val("b2b_valid_end", 32'(bus8.out_valid), 32'd1);
    check_val("b2b_second_f", 32'(bus8.out_shares[0] ^ bus8.out_shares[1]), 32'd0);
    check_val("b2b_g_in_clr", 32'(g_in8), 32'd0);
    $display("b2b second result out=%b", bus8.out_shares);
    bus8.out_ready = 1'b1;
    tick();
    bus8.out_ready = 1'b0;
    check_val("b2b_drain", 32'(bus8.out_valid), 32'd0);

    // Async reset in the middle of an evaluation with a refilled buffer
    bus8.rnd_valid = 1'b1; bus8.rnd_data = 8'h5A;
    tick();
    bus8.rnd_data  = 8'hFF;
    bus8.rnd_valid = 1'b0;
    bus8.in_valid  = 1'b1;
    bus8.in_shares = 6'b110000;
    tick();
    bus8.in_valid  = 1'b0;
    bus8.rnd_valid = 1'b1;
    tick();
    bus8.rnd_valid = 1'b0;
    check_val("mid_busy", 32'(busy8), 32'd1);
    check_val("mid_buf_full", 32'(bus8.rnd_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_out_valid", 32'(bus8.out_valid), 32'd0);
    check_val("arst_g_in", 32'(g_in8), 32'd0);
    check_val("arst_g_r", 32'(g_r8), 32'd0);
    check_val("arst_busy", 32'(busy8), 32'd0);
    check_val("arst_buf_empty", 32'(bus8.rnd_ready), 32'd1);
    check_val("arst_in_ready", 32'(bus8.in_ready), 32'd0);
    $display("async reset applied mid-evaluation");
    tick();
    rst_n = 1'b1;

    // RW=1 bit-serial collection
    bus1.in_valid  = 1'b1;
    bus1.in_shares = 6'b111111;             // A=B=C=0 -> F=1
`ifdef SYSX_STALL_CNT_EN
    repeat (10) tick();
    check_val("stall_cnt", 32'(stall1), 32'd10);
    $display("stall count=%0d", stall1);
`endif
    pat = 8'b0100_1101;
    for (int j = 0; j < 8; j++) begin
      check_val("rw1_in_ready_low", 32'(bus1.in_ready), 32'd0);
      bus1.rnd_valid = 1'b1;
      bus1.rnd_data  = pat[j];
      tick();
    end
    bus1.rnd_valid = 1'b0;
    check_val("rw1_in_ready_high", 32'(bus1.in_ready), 32'd1);
    check_val("rw1_rnd_ready", 32'(bus1.rnd_ready), 32'd0);
    tick();
    bus1.in_valid = 1'b0;
    check_val("rw1_g_r", 32'(g_r1), 32'h4D);
    lat = 0;
    while (!bus1.out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check_val("rw1_latency", 32'(lat), 32'(LAT));
    check_val("rw1_f", 32'(bus1.out_shares[0] ^ bus1.out_shares[1]), 32'd1);
    $display("rw1 eval r=%h out=%b latency=%0d", 8'h4D, bus1.out_shares, lat);
    bus1.out_ready = 1'b1;
    tick();
    bus1.out_ready = 1'b0;
    check_val("rw1_drain", 32'(bus1.out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
